// File: rtl/vga_text_pkg.sv
// Shared definitions for the letter scroller: letter codes, FSM states,
// effect selector encodings and the effect decode helper.
package vga_text_pkg;

    localparam logic [4:0] LETTER_A     = 5'd0;
    localparam logic [4:0] LETTER_B     = 5'd1;
    localparam logic [4:0] LETTER_C     = 5'd2;
    localparam logic [4:0] LETTER_D     = 5'd3;
    localparam logic [4:0] LETTER_E     = 5'd4;
    localparam logic [4:0] LETTER_F     = 5'd5;
    localparam logic [4:0] LETTER_G     = 5'd6;
    localparam logic [4:0] LETTER_H     = 5'd7;
    localparam logic [4:0] LETTER_I     = 5'd8;
    localparam logic [4:0] LETTER_J     = 5'd9;
    localparam logic [4:0] LETTER_K     = 5'd10;
    localparam logic [4:0] LETTER_L     = 5'd11;
    localparam logic [4:0] LETTER_M     = 5'd12;
    localparam logic [4:0] LETTER_N     = 5'd13;
    localparam logic [4:0] LETTER_O     = 5'd14;
    localparam logic [4:0] LETTER_P     = 5'd15;
    localparam logic [4:0] LETTER_Q     = 5'd16;
    localparam logic [4:0] LETTER_R     = 5'd17;
    localparam logic [4:0] LETTER_S     = 5'd18;
    localparam logic [4:0] LETTER_T     = 5'd19;
    localparam logic [4:0] LETTER_U     = 5'd20;
    localparam logic [4:0] LETTER_V     = 5'd21;
    localparam logic [4:0] LETTER_W     = 5'd22;
    localparam logic [4:0] LETTER_X     = 5'd23;
    localparam logic [4:0] LETTER_Y     = 5'd24;
    localparam logic [4:0] LETTER_BLANK = 5'd31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        PAUSE  = 2'd2
    } scroll_state_e;

    typedef enum logic [1:0] {
        EFF_STEADY  = 2'd0,
        EFF_SHINE   = 2'd1,
        EFF_AMBIANT = 2'd2,
        EFF_NONE    = 2'd3
    } effect_sel_e;

    // One-hot effect strobes packed as {ambiant, shine, steady}.
    function automatic logic [2:0] effect_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            EFF_STEADY:  oh = 3'b001;
            EFF_SHINE:   oh = 3'b010;
            EFF_AMBIANT: oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// While hold is high the counter is forced to zero and no tick is produced.
module vga_tick_gen #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and tick decode; wrap at the last phase.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (hold) begin
            cnt_d = {CW{1'b0}};
            tick  = 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            tick  = 1'b0;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_letter_scroller.sv
// Message buffer and scrolling window feeding the per-letter colourisers.
// Optional build macro SCROLL_ONESHOT_EN: when defined, scrolling stops and
// returns to IDLE after one full pass of message plus trailing blanks.
module vga_letter_scroller
    import vga_text_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SLOTS    = 4,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [4:0]                 wr_letter,
    input  logic                       clr,
    input  logic                       start,
    input  logic [1:0]                 effect_sel,
    output logic [5*SLOTS-1:0]         letters,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       busy,
    output logic                       valid,
    output logic                       steady,
    output logic                       shine,
    output logic                       ambiant
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Offset must reach count + SLOTS - 1 and hold offset + slot sums.
    localparam int unsigned OW = $clog2(DEPTH + SLOTS) + 1;

    scroll_state_e        state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [OW-1:0]        offset_q, offset_d;
    logic [4:0]           msg_q [DEPTH];
    logic                 msg_we_s;
    logic [5*SLOTS-1:0]   letters_q, letters_d;
    logic                 full_q, busy_q, valid_q;
    logic [2:0]           effect_q;
    logic                 tick_s;
    logic                 hold_s;
    logic [OW-1:0]        last_s;
    logic [OW-1:0]        pos_s;

    // clr also clears the divider on the same edge it forces IDLE.
    assign hold_s = (state_q == IDLE) || clr;

    vga_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .hold (hold_s),
        .tick (tick_s)
    );

    // FSM next state, message count and scroll offset; clr > start > wr_en.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        offset_d = offset_q;
        msg_we_s = 1'b0;
        last_s   = OW'(count_q) + OW'(SLOTS - 1);
        if (clr) begin
            state_d  = IDLE;
            count_d  = {CW{1'b0}};
            offset_d = {OW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_q != {CW{1'b0}}) begin
                            state_d = SCROLL;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (wr_en && !full_q) begin
                        msg_we_s = 1'b1;
                        count_d  = count_q + CW'(1);
                    end else begin
                        count_d = count_q;
                    end
                end
                SCROLL: begin
                    if (tick_s) begin
                        if (offset_q == last_s) begin
                            offset_d = {OW{1'b0}};
`ifdef SCROLL_ONESHOT_EN
                            state_d  = IDLE;
`endif
                        end else begin
                            offset_d = offset_q + OW'(1);
                        end
                    end else begin
                        offset_d = offset_q;
                    end
                    // A tick on the same edge still advances before pausing.
                    if (start && (state_d == SCROLL)) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = state_d;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = SCROLL;
                    end else begin
                        state_d = PAUSE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    count_d  = {CW{1'b0}};
                    offset_d = {OW{1'b0}};
                end
            endcase
        end
    end

    // Window decode: slot k shows msg[offset+k] inside the message, else BLANK.
    always_comb begin
        letters_d = {SLOTS{LETTER_BLANK}};
        pos_s     = {OW{1'b0}};
        for (int k = 0; k < SLOTS; k++) begin
            pos_s = offset_q + OW'(k);
            if (pos_s < OW'(count_q)) begin
                letters_d[5*k +: 5] = msg_q[pos_s[AW-1:0]];
            end else begin
                letters_d[5*k +: 5] = LETTER_BLANK;
            end
        end
    end

    // Message storage; entries past count are don't-care but start BLANK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                msg_q[i] <= LETTER_BLANK;
            end
        end else if (msg_we_s) begin
            msg_q[count_q[AW-1:0]] <= wr_letter;
        end else begin
            msg_q <= msg_q;
        end
    end

    // Control state and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= {CW{1'b0}};
            offset_q  <= {OW{1'b0}};
            letters_q <= {SLOTS{LETTER_BLANK}};
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            effect_q  <= 3'b000;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            offset_q  <= offset_d;
            letters_q <= letters_d;
            full_q    <= (count_d == CW'(DEPTH));
            busy_q    <= (state_d != IDLE);
            valid_q   <= tick_s;
            effect_q  <= effect_onehot(effect_sel);
        end
    end

    assign letters = letters_q;
    assign count   = count_q;
    assign full    = full_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign steady  = effect_q[0];
    assign shine   = effect_q[1];
    assign ambiant = effect_q[2];

endmodule

// File: tb/tb_vga_letter_scroller.sv
// Self-checking bench for vga_letter_scroller: directed scenarios followed by
// random stimulus, every cycle compared with a behavioural message model.
module tb_vga_letter_scroller;

    localparam int DEPTH    = 8;
    localparam int SLOTS    = 4;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_letter = 5'd0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  effect_sel = 2'd3;
    logic [19:0] letters;
    logic [3:0]  count;
    logic        full, busy, valid, steady, shine, ambiant;

    vga_letter_scroller #(
        .DEPTH    (DEPTH),
        .SLOTS    (SLOTS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_letter  (wr_letter),
        .clr        (clr),
        .start      (start),
        .effect_sel (effect_sel),
        .letters    (letters),
        .count      (count),
        .full       (full),
        .busy       (busy),
        .valid      (valid),
        .steady     (steady),
        .shine      (shine),
        .ambiant    (ambiant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: message array, count, offset into the virtual
    // sequence (message + SLOTS blanks), mode 0=idle 1=scroll 2=pause, and
    // cycles spent active since leaving idle.
    int          m_msg [DEPTH];
    int          m_count, m_offset, m_mode, m_phase;
    logic [19:0] e_letters;
    logic        e_valid;
    logic [2:0]  e_eff;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [19:0] model_window();
        logic [19:0] w;
        int p;
        w = 20'd0;
        for (int k = 0; k < SLOTS; k++) begin
            p = m_offset + k;
            w[5*k +: 5] = (p < m_count) ? 5'(m_msg[p]) : 5'd31;
        end
        return w;
    endfunction

    task automatic model_reset();
        m_count   = 0;
        m_offset  = 0;
        m_mode    = 0;
        m_phase   = 0;
        e_letters = 20'hFFFFF;
        e_valid   = 1'b0;
        e_eff     = 3'b000;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic tick;
        tick      = (m_mode != 0) && !clr && ((m_phase % TICK_DIV) == TICK_DIV - 1);
        e_valid   = tick;
        e_letters = model_window();
        e_eff     = {effect_sel == 2'd2, effect_sel == 2'd1, effect_sel == 2'd0};
        if (clr) begin
            m_mode   = 0;
            m_count  = 0;
            m_offset = 0;
            m_phase  = 0;
        end else begin
            m_phase = (m_mode != 0) ? m_phase + 1 : 0;
            case (m_mode)
                0: begin
                    if (start) begin
                        if (m_count > 0) m_mode = 1;
                    end else if (wr_en && m_count < DEPTH) begin
                        m_msg[m_count] = int'(wr_letter);
                        m_count++;
                    end
                end
                1: begin
                    if (tick) begin
                        m_offset = (m_offset + 1) % (m_count + SLOTS);
`ifdef SCROLL_ONESHOT_EN
                        if (m_offset == 0) m_mode = 0;
`endif
                    end
                    if (start && m_mode == 1) m_mode = 2;
                end
                default: begin
                    if (start) m_mode = 1;
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        check_value("letters", 32'(letters), 32'(e_letters));
        check_value("count",   32'(count),   32'(m_count));
        check_value("full",    32'(full),    32'(m_count == DEPTH));
        check_value("busy",    32'(busy),    32'(m_mode != 0));
        check_value("valid",   32'(valid),   32'(e_valid));
        check_value("steady",  32'(steady),  32'(e_eff[0]));
        check_value("shine",   32'(shine),   32'(e_eff[1]));
        check_value("ambiant", 32'(ambiant), 32'(e_eff[2]));
    endtask

    task automatic step(input logic w, input logic [4:0] l, input logic c,
                        input logic s, input logic [1:0] e);
        @(negedge clk);
        wr_en      = w;
        wr_letter  = l;
        clr        = c;
        start      = s;
        effect_sel = e;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // Asynchronous reset applied away from the clock edge; checked at once.
    task automatic apply_reset();
        @(negedge clk);
        wr_en = 1'b0; clr = 1'b0; start = 1'b0; effect_sel = 2'd3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] hello [5];
        hello[0] = 5'd7; hello[1] = 5'd4; hello[2] = 5'd11; hello[3] = 5'd11; hello[4] = 5'd14;

        apply_reset();

        // Load HELLO and see the first window.
        for (int i = 0; i < 5; i++) step(1'b1, hello[i], 1'b0, 1'b0, 2'd3);
        check_value("hello_count", 32'(count), 32'd5);
        step(1'b0, 5'd0, 1'b0, 1'b0, 2'd3);
        check_value("hello_win", 32'(letters), 32'({5'd11, 5'd11, 5'd4, 5'd7}));

        // Scroll through more than one full wrap with shine selected.
        step(1'b0, 5'd0, 1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 45; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 2'd1);

        // Pause across several ticks, then resume.
        step(1'b0, 5'd0, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 13; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 5'd0, 1'b0, 1'b1, 2'd2);
        for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 2'd2);

        // clr together with start returns to IDLE and blanks the window.
        step(1'b0, 5'd0, 1'b1, 1'b1, 2'd3);
        step(1'b0, 5'd0, 1'b0, 1'b0, 2'd3);
        check_value("clr_win", 32'(letters), 32'hFFFFF);
        check_value("clr_count", 32'(count), 32'd0);

        // Overfill: nine writes, the last one dropped.
        for (int i = 0; i < 9; i++) step(1'b1, 5'($urandom_range(0, 24)), 1'b0, 1'b0, 2'd3);
        check_value("fill_count", 32'(count), 32'd8);
        check_value("fill_full", 32'(full), 32'd1);

        // Scroll, then reset in the middle of it.
        step(1'b0, 5'd0, 1'b0, 1'b1, 2'd3);
        for (int i = 0; i < 22; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 2'd3);
        apply_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 24)),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : effect_sel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
